// File: rtl/booth4_seq_mult.sv
// booth4_seq_mult: iterative radix-4 (modified Booth) multiplier.
// Retires one Booth digit (two multiplier bits) per clock over N = WIDTH/2 + 1
// iterations. Operands are extended to WIDTH+2 bits when an operation is
// accepted, so one datapath covers both signed and unsigned mode exactly.
// start/busy/done handshake; p holds its value until the next result lands.
module booth4_seq_mult #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int N  = WIDTH / 2 + 1;  // Booth iterations
   localparam int CW = $clog2(N);      // iteration counter width
   localparam int XW = WIDTH + 2;      // extended operand width
   localparam int AW = WIDTH + 3;      // upper accumulator width

   localparam logic [AW-1:0] ONE      = AW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [XW-1:0]        x_q, x_d;      // extended multiplicand
   logic [AW-1:0]        acc_q, acc_d;  // upper accumulator
   logic [XW-1:0]        mul_q, mul_d;  // multiplier, shifted right 2 bits per step
   logic                 ym1_q, ym1_d;  // previous multiplier bit, y[2i-1]
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [2*WIDTH-1:0]   p_q, p_d;

   logic [2:0]           digit;
   logic [AW-1:0]        x_ext, x2_ext, multiple, acc_sum, acc_shift;
   logic [XW-1:0]        mul_shift;

   // Sign- or zero-extend an operand to WIDTH+2 bits depending on the mode.
   function automatic logic [XW-1:0] extend(input logic [WIDTH-1:0] v, input logic sm);
      return sm ? {{2{v[WIDTH-1]}}, v} : {2'b00, v};
   endfunction

   // One Booth step: select digit*X, add into the accumulator, shift the pair right by 2.
   always_comb begin : booth_step
      x_ext    = {x_q[XW-1], x_q};
      x2_ext   = {x_q, 1'b0};
      digit    = {mul_q[1:0], ym1_q};
      multiple = '0;
      case (digit)
         3'b001, 3'b010: multiple = x_ext;
         3'b011:         multiple = x2_ext;
         3'b100:         multiple = ~x2_ext + ONE;
         3'b101, 3'b110: multiple = ~x_ext + ONE;
         default:        multiple = '0;
      endcase
      acc_sum   = acc_q + multiple;
      acc_shift = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
      mul_shift = {acc_sum[1:0], mul_q[XW-1:2]};
   end

   // Next-state logic for the FSM, datapath and registered outputs.
   always_comb begin : next_state
      // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      acc_d   = acc_q;
      mul_d   = mul_q;
      ym1_d   = ym1_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      p_d     = p_q;

      case (state_q)
         IDLE, DONE: begin
            // DONE accepts a new start just like IDLE, giving back-to-back operation.
            if (start) begin
               state_d = RUN;
               busy_d  = 1'b1;
               cnt_d   = '0;
               x_d     = extend(x, signed_mode);
               mul_d   = extend(y, signed_mode);
               acc_d   = '0;
               ym1_d   = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            busy_d = 1'b1;
            acc_d  = acc_shift;
            mul_d  = mul_shift;
            ym1_d  = mul_q[1];
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               // After 2N shifts the low product bits sit in mul, the rest in acc.
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cnt_d   = '0;
               p_d     = {acc_shift[WIDTH-3:0], mul_shift};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin : regs
      // NOTE: datapath registers are cleared too, so an aborted operation leaves nothing behind.
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         acc_q   <= '0;
         mul_q   <= '0;
         ym1_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         p_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         acc_q   <= acc_d;
         mul_q   <= mul_d;
         ym1_q   <= ym1_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         p_q     <= p_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;

endmodule

// File: tb/tb_booth4_seq_mult.sv
// Testbench for booth4_seq_mult: WIDTH=16 directed and random operations plus an
// exhaustive WIDTH=4 sweep, all checked against plain integer multiplication.
module tb_booth4_seq_mult;

   localparam int W   = 16;
   localparam int N   = W / 2 + 1;
   localparam int LAT = N + 1;    // negedges from the accept edge to the done cycle
   localparam int LAT4 = 4 / 2 + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, signed_mode;
   logic [W-1:0]  x, y;
   logic          busy, done;
   logic [2*W-1:0] p;

   logic          start4, sm4;
   logic [3:0]    x4, y4;
   logic          busy4, done4;
   logic [7:0]    p4;

   int n_checks = 0;
   int n_fail   = 0;

   booth4_seq_mult #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .x(x), .y(y), .busy(busy), .done(done), .p(p)
   );

   booth4_seq_mult #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
      .x(x4), .y(y4), .busy(busy4), .done(done4), .p(p4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref16(input logic sm, input logic [15:0] a, input logic [15:0] b);
      longint la, lb, pr;
      la = sm ? {{48{a[15]}}, a} : {48'd0, a};
      lb = sm ? {{48{b[15]}}, b} : {48'd0, b};
      pr = la * lb;
      return pr[31:0];
   endfunction

   function automatic logic [7:0] ref4(input logic sm, input logic [3:0] a, input logic [3:0] b);
      longint la, lb, pr;
      la = sm ? {{60{a[3]}}, a} : {60'd0, a};
      lb = sm ? {{60{b[3]}}, b} : {60'd0, b};
      pr = la * lb;
      return pr[7:0];
   endfunction

   // Full 16-bit operation: latency, busy length, p stability during RUN, result, pulse width.
   task automatic run_op(input logic sm, input logic [15:0] a, input logic [15:0] b, input string tag);
      int          lat, busy_cnt;
      bit          p_moved;
      logic [31:0] p_prev, exp;
      exp = ref16(sm, a, b);
      @(negedge clk);
      start = 1'b1; signed_mode = sm; x = a; y = b;
      p_prev = p;
      @(negedge clk);
      // Scramble the inputs: the DUT must use the values latched with start.
      start = 1'b0; signed_mode = ~sm; x = 16'($urandom); y = 16'($urandom);
      lat = 1; busy_cnt = 0; p_moved = 1'b0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) busy_cnt++;
         if (p !== p_prev) p_moved = 1'b1;
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(LAT));
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(N));
      check({tag, "_p_stable_in_run"}, 64'(p_moved), 64'(0));
      check({tag, "_p"}, 64'(p), 64'(exp));
      check({tag, "_busy_in_done"}, 64'(busy), 64'(0));
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
   endtask

   initial begin
      int          lat, seen_done;
      logic [31:0] exp_a, exp_b;
      logic        sm;
      logic [15:0] a, b;
      logic [15:0] corners [6];

      corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};

      rst = 1'b1; start = 1'b0; signed_mode = 1'b0; x = '0; y = '0;
      start4 = 1'b0; sm4 = 1'b0; x4 = '0; y4 = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      check("reset_p", 64'(p), 64'(0));
      check("reset_busy4", 64'(busy4), 64'(0));
      rst = 1'b0;

      // Directed corner operations.
      run_op(1'b1, 16'h8000, 16'h8000, "s_min_min");
      check("s_min_min_const", 64'(p), 64'h4000_0000);
      run_op(1'b0, 16'hFFFF, 16'hFFFF, "u_max_max");
      check("u_max_max_const", 64'(p), 64'hFFFE_0001);
      run_op(1'b1, 16'hFFFF, 16'hFFFF, "s_m1_m1");
      check("s_m1_m1_const", 64'(p), 64'h0000_0001);
      run_op(1'b1, 16'hFFFF, 16'h0001, "s_m1_p1");
      check("s_m1_p1_const", 64'(p), 64'hFFFF_FFFF);
      run_op(1'b0, 16'h0003, 16'h0000, "u_zero");
      check("u_zero_const", 64'(p), 64'h0);
      run_op(1'b1, 16'h7FFF, 16'h8000, "s_max_min");

      // Start pulses during RUN are ignored; start in the DONE cycle is accepted.
      exp_a = ref16(1'b1, 16'h1234, 16'hFEDC);
      exp_b = ref16(1'b0, 16'hABCD, 16'h00FF);
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b1; x = 16'h1234; y = 16'hFEDC;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         if (lat == 3 || lat == 5) begin
            start = 1'b1; signed_mode = 1'b0; x = 16'h5555; y = 16'h3333;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      check("ignore_start_latency", 64'(lat), 64'(LAT));
      check("ignore_start_p", 64'(p), 64'(exp_a));
      start = 1'b1; signed_mode = 1'b0; x = 16'hABCD; y = 16'h00FF;
      @(negedge clk);
      start = 1'b0;
      check("b2b_done_single", 64'(done), 64'(0));
      check("b2b_busy", 64'(busy), 64'(1));
      check("b2b_p_held", 64'(p), 64'(exp_a));
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_latency", 64'(lat), 64'(LAT));
      check("b2b_p", 64'(p), 64'(exp_b));

      // Reset in the middle of an operation aborts it.
      run_op(1'b0, 16'h0003, 16'h0005, "pre_abort");
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b0; x = 16'h0102; y = 16'h0304;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_p", 64'(p), 64'(0));
      seen_done = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) seen_done = 1;
      end
      check("abort_no_done", 64'(seen_done), 64'(0));

      // Random operations, mixing in corner operands.
      for (int i = 0; i < 1500; i++) begin
         sm = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
         run_op(sm, a, b, "rand");
      end

      // Exhaustive WIDTH=4, both modes.
      for (int m = 0; m < 2; m++) begin
         for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
               @(negedge clk);
               start4 = 1'b1; sm4 = 1'(m); x4 = 4'(ia); y4 = 4'(ib);
               @(negedge clk);
               start4 = 1'b0;
               lat = 1;
               while (done4 !== 1'b1 && lat < 20) begin
                  @(negedge clk);
                  lat++;
               end
               check("w4_latency", 64'(lat), 64'(LAT4));
               check("w4_p", 64'(p4), 64'(ref4(1'(m), 4'(ia), 4'(ib))));
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
